// File: rtl/fetchie_boot_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetchie_boot_pkg : shared types and constants for the UART boot loader
// Revision: 1.0
// ---------------------------------------------------------------------------
package fetchie_boot_pkg;

  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    DATA_LO = 3'd3,
    DATA_HI = 3'd4,
    DONE    = 3'd5
  } loader_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         BYTES_PER_WORD    = 2;

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_core : 8N1 UART receiver with start-glitch rejection and stop check
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_rx_core
  import fetchie_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       stop_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_half_cnt = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_rx_meta;
  logic             r_rx_sync;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             r_stop_err;

  rx_state_t        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_valid_nxt;
  logic             w_err_nxt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      r_rx_meta    <= rx;
      r_rx_sync    <= r_rx_meta;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_byte_valid <= w_valid_nxt;
      r_stop_err   <= w_err_nxt;
    end
  end

  // Start bit is checked half a bit in; every later sample lands mid-bit.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_valid_nxt   = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_sync) w_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_cnt == c_half_cnt) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = r_rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == c_full_cnt) begin
          w_cnt_nxt     = '0;
          w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == c_full_cnt) begin
          w_cnt_nxt = '0;
          if (r_rx_sync) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        w_cnt_nxt = '0;
        if (r_rx_sync) w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign byte_data  = r_shift;
  assign byte_valid = r_byte_valid;
  assign stop_err   = r_stop_err;

endmodule
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_boot_loader : loads a length-prefixed image from UART into SPRAM
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_boot_loader
  import fetchie_boot_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 104,
  parameter int         ADDR_WIDTH   = 15,
  parameter int         DATA_WIDTH   = 16,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  rx,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err
);

  localparam logic [32:0] c_max_words = 33'd1 << ADDR_WIDTH;

  logic [7:0] w_byte_data;
  logic       w_byte_valid;
  logic       w_stop_err;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .rx        (rx),
    .byte_data (w_byte_data),
    .byte_valid(w_byte_valid),
    .stop_err  (w_stop_err)
  );

  loader_state_t         r_state;
  logic [7:0]            r_len_lo;
  logic [15:0]           r_remaining;
  logic [7:0]            r_lo_byte;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wen;
  logic                  r_busy;
  logic                  r_err;
  logic                  r_cpu_reset_n;

  loader_state_t         w_state_nxt;
  logic [7:0]            w_len_lo_nxt;
  logic [15:0]           w_remaining_nxt;
  logic [7:0]            w_lo_byte_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic                  w_wen_nxt;
  logic                  w_busy_nxt;
  logic                  w_err_nxt;
  logic [15:0]           w_len;
  logic                  w_in_frame;

  assign w_len      = {w_byte_data, r_len_lo};
  assign w_in_frame = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                      (r_state == DATA_LO) || (r_state == DATA_HI);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= SYNC;
      r_len_lo      <= '0;
      r_remaining   <= '0;
      r_lo_byte     <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wen         <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
      r_cpu_reset_n <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_len_lo      <= w_len_lo_nxt;
      r_remaining   <= w_remaining_nxt;
      r_lo_byte     <= w_lo_byte_nxt;
      r_addr        <= w_addr_nxt;
      r_wdata       <= w_wdata_nxt;
      r_wen         <= w_wen_nxt;
      r_busy        <= w_busy_nxt;
      r_err         <= w_err_nxt;
      r_cpu_reset_n <= (r_state == DONE);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_len_lo_nxt    = r_len_lo;
    w_remaining_nxt = r_remaining;
    w_lo_byte_nxt   = r_lo_byte;
    // Address advances the cycle after each write pulse, so it is stable during it.
    w_addr_nxt      = r_wen ? r_addr + 1'b1 : r_addr;
    w_wdata_nxt     = r_wdata;
    w_wen_nxt       = 1'b0;
    w_busy_nxt      = r_busy;
    w_err_nxt       = r_err;
    if (w_stop_err) begin
      w_err_nxt = 1'b1;
      if (w_in_frame) begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = SYNC;
      end
    end else if (w_byte_valid) begin
      case (r_state)
        SYNC: begin
          if (w_byte_data == SYNC_BYTE) begin
            w_busy_nxt  = 1'b1;
            w_state_nxt = LEN_LO;
          end
        end
        LEN_LO: begin
          w_len_lo_nxt = w_byte_data;
          w_state_nxt  = LEN_HI;
        end
        LEN_HI: begin
          if (w_len == 16'd0) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = DONE;
          end else if ({17'd0, w_len} > c_max_words) begin
            w_err_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = SYNC;
          end else begin
            w_remaining_nxt = w_len;
            w_addr_nxt      = '0;
            w_state_nxt     = DATA_LO;
          end
        end
        DATA_LO: begin
          w_lo_byte_nxt = w_byte_data;
          w_state_nxt   = DATA_HI;
        end
        DATA_HI: begin
          w_wdata_nxt     = {w_byte_data, r_lo_byte};
          w_wen_nxt       = 1'b1;
          w_remaining_nxt = r_remaining - 16'd1;
          if (r_remaining == 16'd1) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = DATA_LO;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_wen     = r_wen;
  assign ram_addr    = r_addr;
  assign ram_wdata   = r_wdata;
  assign cpu_reset_n = r_cpu_reset_n;
  assign busy        = r_busy;
  assign done        = (r_state == DONE);
  assign frame_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_boot_loader : scoreboard bench for the UART boot loader
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_uart_boot_loader;

  localparam int CPB = 8;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        rx = 1'b1;
  logic        ram_wen;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        cpu_reset_n;
  logic        busy;
  logic        done;
  logic        frame_err;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  failures = 0;
  int  wen_count = 0;
  int  cyc = 0;
  int  done_rise = -1;
  int  cpu_rise = -1;
  logic done_d = 1'b0;
  logic cpu_d = 1'b0;

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (15),
    .DATA_WIDTH  (16),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .rx         (rx),
    .ram_wen    (ram_wen),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .cpu_reset_n(cpu_reset_n),
    .busy       (busy),
    .done       (done),
    .frame_err  (frame_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Write scoreboard: every pulse must match the oldest expected write.
  always @(negedge CLK) begin
    if (RESET_N && ram_wen === 1'b1) begin
      wen_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h required=no write", ram_addr, ram_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (ram_addr !== mon_e.addr || ram_wdata !== mon_e.data) begin
          failures++;
          $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                   ram_addr, ram_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
    if (done === 1'b1 && done_d !== 1'b1) done_rise = cyc;
    if (cpu_reset_n === 1'b1 && cpu_d !== 1'b1) cpu_rise = cyc;
    done_d = done;
    cpu_d  = cpu_reset_n;
  end

  task automatic push_exp(input logic [14:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge CLK);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge CLK);
    rx = 1'b1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge CLK);
    exp_q.delete();
    wen_count = 0;
    done_rise = -1;
    cpu_rise = -1;
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 * CPB; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({ram_wen, ram_addr, ram_wdata} !== 32'd0) begin
      failures++;
      $display("FAIL reset_ram got wen=%b addr=%h data=%h required 0/0/0", ram_wen, ram_addr, ram_wdata);
    end
    checks++;
    if ({cpu_reset_n, busy, done, frame_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got cpu_rst_n/busy/done/err=%b required 0000",
               {cpu_reset_n, busy, done, frame_err});
    end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    push_exp(15'd0, 16'h1234);
    push_exp(15'd1, 16'h5678);
    send_byte(8'hA5);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got %b required 1", busy);
    end
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h78); send_byte(8'h56);
    wait_done(ok);
    repeat (3) @(negedge CLK);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_done got timeout required done=1");
    end
    checks++;
    if (cpu_rise - done_rise !== 1 || cpu_reset_n !== 1'b1) begin
      failures++;
      $display("FAIL basic_cpu_release got delay=%0d cpu_reset_n=%b required delay=1 cpu_reset_n=1",
               cpu_rise - done_rise, cpu_reset_n);
    end
    checks++;
    if (wen_count !== 2 || exp_q.size() !== 0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_end got writes=%0d pending=%0d err=%b busy=%b required 2/0/0/0",
               wen_count, exp_q.size(), frame_err, busy);
    end
    checks++;
    if (ram_addr !== 15'd2) begin
      failures++;
      $display("FAIL basic_addr_after got %h required 0002", ram_addr);
    end
  endtask

  task automatic test_ignore_and_empty();
    bit ok;
    do_reset();
    send_byte(8'h3C);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_busy got %b required 0", busy);
    end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    wait_done(ok);
    repeat (3) @(negedge CLK);
    checks++;
    if (!ok || wen_count !== 0 || cpu_reset_n !== 1'b1 || cpu_rise - done_rise !== 1) begin
      failures++;
      $display("FAIL empty_frame got done=%b writes=%0d cpu_reset_n=%b delay=%0d required 1/0/1/1",
               ok, wen_count, cpu_reset_n, cpu_rise - done_rise);
    end
  endtask

  task automatic test_stop_err();
    bit ok;
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h34); send_byte(8'h12, 1'b0);
    repeat (4 * CPB) @(negedge CLK);
    checks++;
    if ({frame_err, busy, done, cpu_reset_n} !== 4'b1000 || wen_count !== 0) begin
      failures++;
      $display("FAIL stop_err got err/busy/done/cpu=%b writes=%0d required 1000/0",
               {frame_err, busy, done, cpu_reset_n}, wen_count);
    end
    push_exp(15'd0, 16'hABCD);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hCD); send_byte(8'hAB);
    wait_done(ok);
    repeat (2) @(negedge CLK);
    checks++;
    if (!ok || wen_count !== 1 || exp_q.size() !== 0 || frame_err !== 1'b1) begin
      failures++;
      $display("FAIL stop_err_recover got done=%b writes=%0d pending=%0d err=%b required 1/1/0/1",
               ok, wen_count, exp_q.size(), frame_err);
    end
  endtask

  task automatic test_glitch();
    bit ok;
    do_reset();
    send_byte(8'hA5);
    rx = 1'b0;
    repeat (3) @(negedge CLK);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge CLK);
    checks++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch got err=%b busy=%b required 0/1", frame_err, busy);
    end
    push_exp(15'd0, 16'hBEEF);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE);
    wait_done(ok);
    repeat (2) @(negedge CLK);
    checks++;
    if (!ok || wen_count !== 1 || exp_q.size() !== 0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL glitch_frame got done=%b writes=%0d pending=%0d err=%b required 1/1/0/0",
               ok, wen_count, exp_q.size(), frame_err);
    end
  endtask

  task automatic test_len_bounds();
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h80);
    repeat (4) @(negedge CLK);
    checks++;
    if ({frame_err, busy, done} !== 3'b100 || wen_count !== 0) begin
      failures++;
      $display("FAIL len_over got err/busy/done=%b writes=%0d required 100/0",
               {frame_err, busy, done}, wen_count);
    end
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h80);
    repeat (4) @(negedge CLK);
    checks++;
    if ({frame_err, busy, done} !== 3'b010) begin
      failures++;
      $display("FAIL len_max got err/busy/done=%b required 010", {frame_err, busy, done});
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
    rx = 1'b0;
    repeat (CPB * 3) @(negedge CLK);
    rx = 1'b1;
    @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({ram_wen, ram_addr, ram_wdata, cpu_reset_n, busy, done, frame_err} !== 36'd0) begin
      failures++;
      $display("FAIL reset_async got wen=%b addr=%h data=%h cpu/busy/done/err=%b required all 0",
               ram_wen, ram_addr, ram_wdata, {cpu_reset_n, busy, done, frame_err});
    end
    do_reset();
    push_exp(15'd0, 16'h1234);
    push_exp(15'd1, 16'h5678);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h78); send_byte(8'h56);
    wait_done(ok);
    repeat (2) @(negedge CLK);
    checks++;
    if (!ok || wen_count !== 2 || exp_q.size() !== 0 || cpu_reset_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_reload got done=%b writes=%0d pending=%0d cpu=%b required 1/2/0/1",
               ok, wen_count, exp_q.size(), cpu_reset_n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_and_empty();
    test_stop_err();
    test_glitch();
    test_len_bounds();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Receives a program image over the UART RX pin and writes it, word by word, into the ice40up5k_spram instruction/data RAM. It is the stage directly upstream of the RAM and the cpu. While loading, it holds the cpu in reset. It releases the cpu once the full image has been written.

Parameters:
CLKS_PER_BIT, 104, CLK cycles per UART bit (12 MHz / 115200); minimum 4.
ADDR_WIDTH, 15, SPRAM word address width (32768 words).
DATA_WIDTH, 16, SPRAM word width; fixed at 2 bytes per word.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
CLK  input  1  system clock
RESET_N  input  1  reset, asynchronous assert, active-low
rx  input  1  UART RX pin, asynchronous to CLK, idle high
ram_wen  output  1  SPRAM write enable, one-cycle pulse per word
ram_addr  output  ADDR_WIDTH  SPRAM word address
ram_wdata  output  DATA_WIDTH  SPRAM write data
cpu_reset_n  output  1  cpu reset, low until load complete
busy  output  1  high from SYNC_BYTE accepted until DONE or error
done  output  1  high in DONE state
frame_err  output  1  sticky error flag, cleared only by reset

Behaviour:
- One clock. Reset is asynchronous and active-low (CLK / RESET_N); every flop is cleared on the RESET_N falling edge.
- Reset values: ram_wen=0, ram_addr=0, ram_wdata=0, cpu_reset_n=0, busy=0, done=0, frame_err=0. Synchroniser flops reset to 1 (line idle).
- RX path:
  - 2-flop synchroniser on rx.
  - Falling edge while the receiver is idle starts a bit counter.
  - At CLKS_PER_BIT/2 the start bit is re-sampled. If it is high, treat it as a glitch and return to idle without setting an error.
  - 8 data bits are sampled at mid-bit, LSB first, every CLKS_PER_BIT.
  - The stop bit is sampled at mid-bit.
    - Stop high: byte_valid pulses for one cycle on the next CLK.
    - Stop low: set frame_err, discard the byte, and wait for the line to return high before re-arming.
- Loader FSM states: SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, DONE.
  - SYNC: a byte equal to SYNC_BYTE goes to LEN_LO and sets busy. Any other byte is ignored.
  - LEN_LO / LEN_HI: capture a 16-bit word count, little-endian.
    - Count 0: go to DONE.
    - Count > 2**ADDR_WIDTH: set frame_err, clear busy, go to SYNC.
    - Otherwise go to DATA_LO with ram_addr=0.
  - DATA_LO: latch the low byte, go to DATA_HI.
  - DATA_HI: on byte_valid, drive ram_wdata={byte,low} and pulse ram_wen for exactly one cycle on the following CLK, with ram_addr stable during the pulse.
    - ram_addr increments in the cycle after the pulse.
    - Remaining count decrements. At 0, go to DONE; otherwise go back to DATA_LO.
    - Latency is 1 cycle from the hi byte_valid to ram_wen.
  - DONE: done=1, busy=0, cpu_reset_n=1 (registered; rises the cycle after DONE is entered). Further RX bytes are received but ignored. Only RESET_N leaves DONE.
- A frame error during LEN_* or DATA_*: set frame_err, clear busy, return to SYNC. ram_addr is not rewound, and words already written stay in RAM. cpu_reset_n stays 0.
- Address wrap: at count == 2**ADDR_WIDTH the last write is at address 2**ADDR_WIDTH-1. The increment that follows wraps ram_addr to 0, and the FSM is already in DONE.
- RESET_N asserted mid-frame aborts immediately. The next frame requires a fresh SYNC_BYTE.
- A byte_valid pulse is never lost: the FSM consumes exactly one byte per pulse. The minimum spacing is 10*CLKS_PER_BIT cycles.

Decomposition:
- Package fetchie_boot_pkg holds:
  - loader_state_t enum (SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, DONE)
  - SYNC_BYTE default constant
  - BYTES_PER_WORD = 2
- Sub-module uart_rx_core contains the synchroniser, the bit timing and the stop-bit check.
  - Parameter: CLKS_PER_BIT.
  - Ports: CLK, RESET_N, rx, byte_data[7:0], byte_valid, stop_err.
- uart_boot_loader instantiates uart_rx_core and contains the loader FSM.

Test Plan:
- Run the bench with CLKS_PER_BIT=8.
- Frame A5 02 00 34 12 78 56 -> ram_wen pulses twice: addr 0 data 16'h1234, then addr 1 data 16'h5678. done=1, then cpu_reset_n=1 one cycle later; frame_err=0.
- Byte 3C, then frame A5 00 00 -> 3C is ignored, DONE is reached with no ram_wen pulse, and cpu_reset_n rises.
- Frame A5 01 00 34 with a low stop bit on the hi byte -> frame_err=1, no ram_wen, state SYNC, cpu_reset_n=0. A following valid A5 01 00 CD AB writes addr 0 = 16'hABCD.
- 3-cycle low glitch on rx while idle -> no byte_valid, no frame_err.
- Length 01 80 (32769) -> frame_err=1, no writes, returns to SYNC.
- RESET_N pulsed low mid-way through the DATA_HI byte -> all outputs return to reset values asynchronously (before the next CLK edge). A subsequent full frame loads correctly from addr 0.
